// File: rtl/idli_sqi_fetch_m.sv
// Instruction fetch sequencer: drives a quad-SPI READ burst and streams
// instruction nibbles (MSB first) to decode with a valid/ready handshake.
//
// Ports:
//   i_sqi_gck, i_sqi_rst_n       clock, async active-low reset
//   o_sqi_cs_n, o_sqi_sio(_oe)   memory chip select and command/address bus
//   i_sqi_sio                    nibble returned by memory
//   o_sqi_data(_vld), i_sqi_data_rdy, o_sqi_pc   decode stream and its PC
//   o_sqi_flush                  discard partially received instruction
//   i_sqi_redir, i_sqi_redir_pc  branch redirect
module idli_sqi_fetch_m #(
   parameter int unsigned DUMMY_CYCLES = 2,
   parameter logic [15:0] RST_PC       = 16'h0000
) (
   input  logic        i_sqi_gck,
   input  logic        i_sqi_rst_n,
   output logic        o_sqi_cs_n,
   output logic [3:0]  o_sqi_sio,
   output logic        o_sqi_sio_oe,
   input  logic [3:0]  i_sqi_sio,
   output logic [3:0]  o_sqi_data,
   output logic        o_sqi_data_vld,
   input  logic        i_sqi_data_rdy,
   output logic [15:0] o_sqi_pc,
   output logic        o_sqi_flush,
   input  logic        i_sqi_redir,
   input  logic [15:0] i_sqi_redir_pc
);

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      ADDR,
      DUMMY,
      DATA
   } state_t;

   state_t      state_q;
   logic [2:0]  cyc_q;
   logic [1:0]  nib_ctr_q;
   logic [15:0] pc_q;
   logic [15:0] fetch_addr_q;
   logic        cs_n_q;
   logic        oe_q;
   logic [3:0]  sio_q;
   logic [3:0]  data_q;
   logic        vld_q;

   logic xfer;
   logic drop;
   logic mid_instr;

   assign xfer      = vld_q && i_sqi_data_rdy;
   assign drop      = vld_q && !i_sqi_data_rdy;
   assign mid_instr = (nib_ctr_q != 2'd0);

   // Decode must forget a partial instruction whenever the stream is
   // broken mid-instruction, whether by a redirect or by a dropped nibble.
   assign o_sqi_flush = mid_instr && (i_sqi_redir || drop);

   assign o_sqi_cs_n     = cs_n_q;
   assign o_sqi_sio      = sio_q;
   assign o_sqi_sio_oe   = oe_q;
   assign o_sqi_data     = data_q;
   assign o_sqi_data_vld = vld_q;
   assign o_sqi_pc       = pc_q;

   always_ff @(posedge i_sqi_gck or negedge i_sqi_rst_n) begin
      if (!i_sqi_rst_n) begin
         state_q      <= IDLE;
         cyc_q        <= 3'd0;
         nib_ctr_q    <= 2'd0;
         pc_q         <= RST_PC;
         fetch_addr_q <= RST_PC;
         cs_n_q       <= 1'b1;
         oe_q         <= 1'b0;
         sio_q        <= 4'h0;
         data_q       <= 4'h0;
         vld_q        <= 1'b0;
      end else begin
         // Accepted nibbles advance the instruction position; the PC
         // moves only once the last nibble of an instruction is taken.
         if (xfer) begin
            nib_ctr_q <= nib_ctr_q + 2'd1;
            if (nib_ctr_q == 2'd3) begin
               pc_q <= pc_q + 16'd1;
            end
         end

         if (i_sqi_redir) begin
            // Redirect overrides everything, including a same-cycle drop.
            state_q      <= IDLE;
            cyc_q        <= 3'd0;
            nib_ctr_q    <= 2'd0;
            pc_q         <= i_sqi_redir_pc;
            fetch_addr_q <= i_sqi_redir_pc;
            cs_n_q       <= 1'b1;
            oe_q         <= 1'b0;
            sio_q        <= 4'h0;
            vld_q        <= 1'b0;
         end else begin
            unique case (state_q)
               IDLE: begin
                  state_q <= CMD;
                  cyc_q   <= 3'd0;
                  cs_n_q  <= 1'b0;
                  oe_q    <= 1'b1;
                  sio_q   <= 4'h0;
               end
               CMD: begin
                  if (cyc_q == 3'd0) begin
                     cyc_q <= 3'd1;
                     sio_q <= 4'h3;
                  end else begin
                     state_q <= ADDR;
                     cyc_q   <= 3'd0;
                     sio_q   <= fetch_addr_q[15:12];
                  end
               end
               ADDR: begin
                  cyc_q <= cyc_q + 3'd1;
                  unique case (cyc_q)
                     3'd0:    sio_q <= fetch_addr_q[11:8];
                     3'd1:    sio_q <= fetch_addr_q[7:4];
                     3'd2:    sio_q <= fetch_addr_q[3:0];
                     default: begin
                        state_q <= DUMMY;
                        cyc_q   <= 3'd0;
                        oe_q    <= 1'b0;
                        sio_q   <= 4'h0;
                     end
                  endcase
               end
               DUMMY: begin
                  if (cyc_q == 3'(DUMMY_CYCLES - 1)) begin
                     state_q <= DATA;
                     cyc_q   <= 3'd0;
                  end else begin
                     cyc_q <= cyc_q + 3'd1;
                  end
               end
               DATA: begin
                  if (drop) begin
                     // Memory cannot stall: end the burst and refetch
                     // the instruction that was being delivered.
                     state_q      <= IDLE;
                     nib_ctr_q    <= 2'd0;
                     fetch_addr_q <= pc_q;
                     cs_n_q       <= 1'b1;
                     vld_q        <= 1'b0;
                  end else begin
                     data_q <= i_sqi_sio;
                     vld_q  <= 1'b1;
                  end
               end
               default: begin
                  state_q <= IDLE;
                  cs_n_q  <= 1'b1;
                  oe_q    <= 1'b0;
                  vld_q   <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
